// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: CH write-back channels, stall hold/bubble, flush, one-deep commit history.
// Optional bubble/hold performance counters are built only when MEM_WB_PERF_EN is defined.
module mem_wb_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned CH        = 2,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [CH*DATA_W-1:0] mem_wdata,
  input  logic [CH*ADDR_W-1:0] mem_waddr,
  input  logic [CH-1:0]        mem_we,
  output logic [CH*DATA_W-1:0] wb_wdata,
  output logic [CH*ADDR_W-1:0] wb_waddr,
  output logic [CH-1:0]        wb_we,
  output logic [CH*DATA_W-1:0] fwd_wdata,
  output logic [CH*ADDR_W-1:0] fwd_waddr,
  output logic [CH-1:0]        fwd_we,
  output logic [15:0]          bubble_cnt,
  output logic [15:0]          hold_cnt
);

  localparam int unsigned DW_ALL = CH * DATA_W;
  localparam int unsigned AW_ALL = CH * ADDR_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } act_e;

  act_e act_c;
  logic s_c;
  logic n_c;
  logic unused_stall_c;

  logic [DW_ALL-1:0] wb_wdata_q, wb_wdata_d;
  logic [AW_ALL-1:0] wb_waddr_q, wb_waddr_d;
  logic [CH-1:0]     wb_we_q,    wb_we_d;
  logic [DW_ALL-1:0] fwd_wdata_q, fwd_wdata_d;
  logic [AW_ALL-1:0] fwd_waddr_q, fwd_waddr_d;
  logic [CH-1:0]     fwd_we_q,    fwd_we_d;

  // Only our own bit and the downstream bit of the stall vector matter here.
  assign s_c            = stall[STAGE_IDX];
  assign n_c            = stall[STAGE_IDX+1];
  assign unused_stall_c = ^stall;

  // Per-edge action, flush first, then stall-bubble, then hold.
  always_comb begin
    act_c = ACT_CAPTURE;
    if (flush) begin
      act_c = ACT_BUBBLE;
    end else if (s_c && !n_c) begin
      act_c = ACT_BUBBLE;
    end else if (s_c) begin
      act_c = ACT_HOLD;
    end
  end

  // Next state: the history register always takes the value committed on this edge.
  always_comb begin
    wb_wdata_d  = wb_wdata_q;
    wb_waddr_d  = wb_waddr_q;
    wb_we_d     = wb_we_q;
    fwd_wdata_d = fwd_wdata_q;
    fwd_waddr_d = fwd_waddr_q;
    fwd_we_d    = fwd_we_q;
    case (act_c)
      ACT_BUBBLE: begin
        fwd_wdata_d = wb_wdata_q;
        fwd_waddr_d = wb_waddr_q;
        fwd_we_d    = wb_we_q;
        wb_wdata_d  = '0;
        wb_waddr_d  = '0;
        wb_we_d     = '0;
      end
      ACT_CAPTURE: begin
        fwd_wdata_d = wb_wdata_q;
        fwd_waddr_d = wb_waddr_q;
        fwd_we_d    = wb_we_q;
        wb_wdata_d  = mem_wdata;
        wb_waddr_d  = mem_waddr;
        wb_we_d     = mem_we;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wdata_q  <= '0;
      wb_waddr_q  <= '0;
      wb_we_q     <= '0;
      fwd_wdata_q <= '0;
      fwd_waddr_q <= '0;
      fwd_we_q    <= '0;
    end else begin
      wb_wdata_q  <= wb_wdata_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_we_q     <= wb_we_d;
      fwd_wdata_q <= fwd_wdata_d;
      fwd_waddr_q <= fwd_waddr_d;
      fwd_we_q    <= fwd_we_d;
    end
  end

  assign wb_wdata  = wb_wdata_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_we     = wb_we_q;
  assign fwd_wdata = fwd_wdata_q;
  assign fwd_waddr = fwd_waddr_q;
  assign fwd_we    = fwd_we_q;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;

  // Saturating event counters.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if ((act_c == ACT_BUBBLE) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if ((act_c == ACT_HOLD) && (hold_cnt_q != {CNT_W{1'b1}})) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

endmodule
